// File: rtl/instr_fetch_unit.sv
// Fetch stage of the KGP-RISC core: owns the PC, reads instruction memory over req/ack
// and hands instructions to decode over valid/ready, honouring branch redirects.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [INSTR_W-1:0] o_instr,
  output logic [5:0]         o_opcode,
  output logic [ADDR_W-1:0]  o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_dec_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD, S_ERR} state_t;

  state_t              r_state,    w_state;
  logic [ADDR_W-1:0]   r_pc,       w_pc;
  logic                r_req,      w_req;
  logic [ADDR_W-1:0]   r_addr,     w_addr;
  logic [INSTR_W-1:0]  r_instr,    w_instr;
  logic [ADDR_W-1:0]   r_instr_pc, w_instr_pc;
  logic                r_valid,    w_valid;
  logic                r_err,      w_err;
  logic                r_squash,   w_squash;
  logic [CNT_W-1:0]    r_wait_cnt, w_wait_cnt;
  logic                w_ack;
  logic                w_xfer;
  logic                w_drop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_squash   <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_req      <= w_req;
      r_addr     <= w_addr;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_valid    <= w_valid;
      r_err      <= w_err;
      r_squash   <= w_squash;
      r_wait_cnt <= w_wait_cnt;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_req      = r_req;
    w_addr     = r_addr;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_valid    = r_valid;
    w_err      = r_err;
    w_squash   = r_squash;
    w_wait_cnt = r_wait_cnt;
    w_ack      = r_req & i_imem_ack;
    w_xfer     = r_valid & i_dec_ready;
    // a word is wrong-path if a redirect is pending or arrives in the same cycle
    w_drop     = i_redirect | r_squash;

    if (i_redirect && (r_state != S_ERR) && (i_redirect_pc[1:0] != 2'b00)) begin
      w_state  = S_ERR;
      w_req    = 1'b0;
      w_valid  = 1'b0;
      w_err    = 1'b1;
      w_squash = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state    = S_BUSY;
          w_req      = 1'b1;
          w_wait_cnt = '0;
          w_pc       = i_redirect ? i_redirect_pc : r_pc;
          w_addr     = i_redirect ? i_redirect_pc : r_pc;
        end
        S_BUSY: begin
          if (w_ack && !w_drop) begin
            w_state    = S_HOLD;
            w_instr    = i_imem_rdata;
            w_instr_pc = r_pc;
            w_valid    = 1'b1;
            w_pc       = r_pc + ADDR_W'(4);
            w_req      = 1'b0;
          end else if (w_ack) begin
            // discard the wrong-path word and reissue at the redirected PC
            w_pc       = i_redirect ? i_redirect_pc : r_pc;
            w_addr     = i_redirect ? i_redirect_pc : r_pc;
            w_squash   = 1'b0;
            w_wait_cnt = '0;
          end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            w_state = S_ERR;
            w_req   = 1'b0;
            w_err   = 1'b1;
          end else begin
            w_wait_cnt = r_wait_cnt + CNT_W'(1);
            if (i_redirect) begin
              w_pc     = i_redirect_pc;
              w_squash = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_redirect || w_xfer) begin
            w_state    = S_BUSY;
            w_valid    = 1'b0;
            w_req      = 1'b1;
            w_wait_cnt = '0;
            w_pc       = i_redirect ? i_redirect_pc : r_pc;
            w_addr     = i_redirect ? i_redirect_pc : r_pc;
          end
        end
        S_ERR: begin
          w_req   = 1'b0;
          w_valid = 1'b0;
          w_err   = 1'b1;
        end
        default: begin
          w_state = S_ERR;
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_addr;
  assign o_instr       = r_instr;
  assign o_opcode      = r_instr[INSTR_W-1 -: 6];
  assign o_instr_pc    = r_instr_pc;
  assign o_instr_valid = r_valid;
  assign o_fetch_err   = r_err;

endmodule
